// File: rtl/stall_control.sv
// Pipeline interlock: load-use bubble and mult/div freeze of PC, F/D and D/X.
// Latency: stall outputs are combinational in the cycle the hazard is seen; mult/div occupies launch..ready+1.
// Backpressure: holds the front end until md_resultRDY or the MD_MAX timeout, then releases in the DONE cycle.
module stall_control #(
    parameter int MD_MAX = 40,
    parameter int CNT_W  = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [4:0]       rs_FD,
    input  logic [4:0]       rt_FD,
    input  logic             uses_rs_FD,
    input  logic             uses_rt_FD,
    input  logic             store_FD,
    input  logic             load_DX,
    input  logic [4:0]       rd_DX,
    input  logic             mult_DX,
    input  logic             div_DX,
    input  logic             md_resultRDY,
    input  logic             md_exception,
    output logic             ctrl_MULT,
    output logic             ctrl_DIV,
    output logic             stall_PC,
    output logic             stall_FD,
    output logic             hold_DX,
    output logic             bubble_DX,
    output logic             bubble_XM,
    output logic             md_result_we,
    output logic             md_ovf,
    output logic             md_busy,
    output logic [CNT_W-1:0] md_cycles
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MD_MAX - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] md_cycles_q;
    logic             ovf_q;

    logic md_op;
    logic launch;
    logic md_stall;
    logic load_use;

    assign md_op    = mult_DX | div_DX;
    assign launch   = (state == IDLE) && md_op;
    assign md_stall = launch || (state == BUSY);

    // sw rt is store data only; the memory-data bypass covers it, so no stall
    assign load_use = load_DX && (rd_DX != 5'd0) &&
                      ((uses_rs_FD && (rs_FD == rd_DX)) ||
                       (uses_rt_FD && !store_FD && (rt_FD == rd_DX)));

    always_ff @(posedge clock) begin
        if (!reset) begin
            state       <= IDLE;
            cnt         <= '0;
            ovf_q       <= 1'b0;
            md_cycles_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (md_op) state <= BUSY;
                end
                BUSY: begin
                    // counter holds on the exit edge so DONE sees the last BUSY count
                    if (md_resultRDY) begin
                        state <= DONE;
                        ovf_q <= md_exception;
                    end else if (cnt == CNT_LAST) begin
                        state <= DONE;
                        ovf_q <= 1'b1;
                    end else if (cnt != '1) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    md_cycles_q <= cnt + 1'b1;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Outputs are gated by reset so they read zero for the whole reset window
    assign ctrl_MULT    = reset && launch && mult_DX;
    assign ctrl_DIV     = reset && launch && div_DX;
    assign stall_PC     = reset && (md_stall || load_use);
    assign stall_FD     = reset && (md_stall || load_use);
    assign hold_DX      = reset && md_stall;
    assign bubble_DX    = reset && !md_stall && load_use;
    assign bubble_XM    = reset && md_stall;
    assign md_result_we = reset && (state == DONE);
    assign md_ovf       = reset && (state == DONE) && ovf_q;
    assign md_busy      = reset && (state != IDLE);
    assign md_cycles    = reset ? md_cycles_q : '0;

endmodule

// File: tb/tb_stall_control.sv
module tb_stall_control;

    localparam int MD_MAX = 40;
    localparam int CNT_W  = 6;

    // {ctrl_MULT, ctrl_DIV, stall_PC, stall_FD, hold_DX, bubble_DX, bubble_XM, md_result_we, md_ovf, md_busy}
    localparam logic [9:0] O_NONE   = 10'b0000000000;
    localparam logic [9:0] O_LMUL   = 10'b1011101000;
    localparam logic [9:0] O_LDIV   = 10'b0111101000;
    localparam logic [9:0] O_BUSY   = 10'b0011101001;
    localparam logic [9:0] O_DONE   = 10'b0000000101;
    localparam logic [9:0] O_DOVF   = 10'b0000000111;
    localparam logic [9:0] O_LU     = 10'b0011010000;

    logic             clock = 1'b0;
    logic             reset;
    logic [4:0]       rs_FD, rt_FD, rd_DX;
    logic             uses_rs_FD, uses_rt_FD, store_FD, load_DX;
    logic             mult_DX, div_DX, md_resultRDY, md_exception;
    logic             ctrl_MULT, ctrl_DIV, stall_PC, stall_FD, hold_DX;
    logic             bubble_DX, bubble_XM, md_result_we, md_ovf, md_busy;
    logic [CNT_W-1:0] md_cycles;

    int checks   = 0;
    int failures = 0;

    stall_control #(.MD_MAX(MD_MAX), .CNT_W(CNT_W)) dut (
        .clock(clock), .reset(reset),
        .rs_FD(rs_FD), .rt_FD(rt_FD),
        .uses_rs_FD(uses_rs_FD), .uses_rt_FD(uses_rt_FD),
        .store_FD(store_FD), .load_DX(load_DX), .rd_DX(rd_DX),
        .mult_DX(mult_DX), .div_DX(div_DX),
        .md_resultRDY(md_resultRDY), .md_exception(md_exception),
        .ctrl_MULT(ctrl_MULT), .ctrl_DIV(ctrl_DIV),
        .stall_PC(stall_PC), .stall_FD(stall_FD), .hold_DX(hold_DX),
        .bubble_DX(bubble_DX), .bubble_XM(bubble_XM),
        .md_result_we(md_result_we), .md_ovf(md_ovf),
        .md_busy(md_busy), .md_cycles(md_cycles)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic expect_outs(input string tag, input logic [9:0] exp);
        @(negedge clock);
        chk(tag, {22'd0, ctrl_MULT, ctrl_DIV, stall_PC, stall_FD, hold_DX,
                  bubble_DX, bubble_XM, md_result_we, md_ovf, md_busy}, {22'd0, exp});
    endtask

    task automatic clear_fd();
        rs_FD = 5'd0; rt_FD = 5'd0; rd_DX = 5'd0;
        uses_rs_FD = 1'b0; uses_rt_FD = 1'b0; store_FD = 1'b0; load_DX = 1'b0;
    endtask

    initial begin
        clear_fd();
        reset = 1'b0; mult_DX = 1'b1; div_DX = 1'b0;
        md_resultRDY = 1'b0; md_exception = 1'b0;

        // reset with a mult sitting in D/X
        expect_outs("rst_c0", O_NONE);
        chk("rst_cyc0", 32'(md_cycles), 32'd0);
        tick();
        expect_outs("rst_c1", O_NONE);
        chk("rst_cyc1", 32'(md_cycles), 32'd0);
        tick(); reset = 1'b1; mult_DX = 1'b0;
        expect_outs("idle", O_NONE);

        // mult, ready at t0+17
        tick(); mult_DX = 1'b1;
        expect_outs("mul_t0", O_LMUL);
        for (int k = 1; k <= 17; k++) begin
            tick(); md_resultRDY = (k == 17);
            expect_outs("mul_busy", O_BUSY);
        end
        tick(); md_resultRDY = 1'b0;
        expect_outs("mul_done", O_DONE);
        tick(); mult_DX = 1'b0;
        expect_outs("mul_idle", O_NONE);
        chk("mul_cycles", 32'(md_cycles), 32'd17);

        // div with exception at t0+5; ready in launch cycle must be ignored
        tick(); div_DX = 1'b1; md_resultRDY = 1'b1; md_exception = 1'b1;
        expect_outs("div_t0", O_LDIV);
        for (int k = 1; k <= 5; k++) begin
            tick(); md_resultRDY = (k == 5); md_exception = (k == 5);
            expect_outs("div_busy", O_BUSY);
        end
        tick(); md_resultRDY = 1'b0; md_exception = 1'b0;
        expect_outs("div_done", O_DOVF);
        // back-to-back mul launches straight away and completes in minimum time
        tick(); div_DX = 1'b0; mult_DX = 1'b1;
        expect_outs("b2b_t0", O_LMUL);
        chk("div_cycles", 32'(md_cycles), 32'd5);
        tick(); md_resultRDY = 1'b1;
        expect_outs("b2b_busy", O_BUSY);
        tick(); md_resultRDY = 1'b0;
        expect_outs("b2b_done", O_DONE);
        tick(); mult_DX = 1'b0;
        expect_outs("b2b_idle", O_NONE);
        chk("b2b_cycles", 32'(md_cycles), 32'd1);

        // timeout
        tick(); mult_DX = 1'b1;
        expect_outs("to_t0", O_LMUL);
        for (int k = 1; k <= MD_MAX; k++) begin
            tick();
            expect_outs("to_busy", O_BUSY);
        end
        tick();
        expect_outs("to_done", O_DOVF);
        tick(); mult_DX = 1'b0;
        expect_outs("to_idle", O_NONE);
        chk("to_cycles", 32'(md_cycles), 32'(MD_MAX));

        // load-use on rs
        tick(); load_DX = 1'b1; rd_DX = 5'd5; uses_rs_FD = 1'b1; rs_FD = 5'd5;
        expect_outs("lu_rs", O_LU);
        tick(); load_DX = 1'b0; rd_DX = 5'd0;
        expect_outs("lu_after", O_NONE);
        // sw data from the load: bypassed, no stall
        tick(); clear_fd(); load_DX = 1'b1; rd_DX = 5'd5;
        uses_rs_FD = 1'b1; rs_FD = 5'd2; uses_rt_FD = 1'b1; rt_FD = 5'd5; store_FD = 1'b1;
        expect_outs("lu_sw", O_NONE);
        tick(); store_FD = 1'b0;
        expect_outs("lu_rt", O_LU);
        // r0 destination never stalls
        tick(); clear_fd(); load_DX = 1'b1; rd_DX = 5'd0; uses_rs_FD = 1'b1; rs_FD = 5'd0;
        expect_outs("lu_r0", O_NONE);
        tick(); clear_fd();

        // reset mid-BUSY abandons the op
        tick(); mult_DX = 1'b1;
        expect_outs("rb_t0", O_LMUL);
        tick();
        expect_outs("rb_t1", O_BUSY);
        tick();
        expect_outs("rb_t2", O_BUSY);
        tick(); reset = 1'b0;
        expect_outs("rb_rst", O_NONE);
        tick(); reset = 1'b1; mult_DX = 1'b0;
        expect_outs("rb_idle", O_NONE);
        chk("rb_cycles", 32'(md_cycles), 32'd0);
        tick();
        expect_outs("rb_idle2", O_NONE);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
